// File: rtl/bram_arbiter.sv
`timescale 1ns/1ps
// Arbitrates an instruction-fetch port and a data port onto one BRAM slave, one transaction at a time.
// Build option: define ROUND_ROBIN_EN to alternate grants on ties; otherwise dmem always wins a tie.
module bram_arbiter #(
    parameter logic [31:0] bram_base_addr = 32'h000000,
    parameter logic [31:0] bram_top_addr  = 32'h100000
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,

    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic        grant_dmem;
    logic        grant_hit;
    logic        pick_dmem;
    logic        pick_hit;
    logic [31:0] pick_addr;
    logic        load_grant;
    logic        finish;
    logic [31:0] resp_data;

`ifdef ROUND_ROBIN_EN
    logic        last_dmem;

    // On a tie the requester that did not win the previous grant goes first.
    always_comb begin
        if (imem_valid && dmem_valid) begin
            pick_dmem = ~last_dmem;
        end else begin
            pick_dmem = dmem_valid;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_dmem <= 1'b0;
        end else if (load_grant) begin
            last_dmem <= pick_dmem;
        end
    end
`else
    always_comb begin
        pick_dmem = dmem_valid;
    end
`endif

    // Unsigned offset compare gives the [base, top) window check in one comparator.
    always_comb begin
        pick_addr = pick_dmem ? dmem_addr : imem_addr;
        pick_hit  = (pick_addr - bram_base_addr) < (bram_top_addr - bram_base_addr);
    end

    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        finish     = 1'b0;
        resp_data  = 32'h0;
        case (state)
            IDLE: begin
                if (imem_valid || dmem_valid) begin
                    state_next = ISSUE;
                    load_grant = 1'b1;
                end
            end
            ISSUE: begin
                if (grant_hit) begin
                    state_next = WAIT;
                end else begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            WAIT: begin
                if (bram_ready) begin
                    state_next = DONE;
                    finish     = 1'b1;
                    resp_data  = bram_rdata;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_dmem <= 1'b0;
            grant_hit  <= 1'b0;
        end else if (load_grant) begin
            grant_dmem <= pick_dmem;
            grant_hit  <= pick_hit;
        end
    end

    // BRAM request fields are loaded on the way into ISSUE so they are registered during the pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bram_valid <= 1'b0;
            bram_instr <= 1'b0;
            bram_addr  <= 32'h0;
            bram_wdata <= 32'h0;
            bram_wstrb <= 4'h0;
        end else begin
            bram_valid <= load_grant && pick_hit;
            if (load_grant && pick_hit) begin
                bram_instr <= ~pick_dmem;
                bram_addr  <= pick_addr;
                bram_wdata <= pick_dmem ? dmem_wdata : 32'h0;
                bram_wstrb <= pick_dmem ? dmem_wstrb : 4'h0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_ready <= 1'b0;
            dmem_ready <= 1'b0;
            imem_rdata <= 32'h0;
            dmem_rdata <= 32'h0;
        end else begin
            imem_ready <= finish && !grant_dmem;
            dmem_ready <= finish && grant_dmem;
            if (finish && !grant_dmem) begin
                imem_rdata <= resp_data;
            end
            if (finish && grant_dmem) begin
                dmem_rdata <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for bram_arbiter: directed cases plus random request pairs predicted
// by a transaction-level model of grant order, response latency, read data and BRAM traffic.
module tb_bram_arbiter;

    localparam logic [31:0] BASE = 32'h000000;
    localparam logic [31:0] TOP  = 32'h100000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } issue_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata = 32'h0;
    logic        bram_ready = 1'b0;

    int          total = 0;
    int          bad = 0;
    issue_t      issue_q[$];
    logic [31:0] slave_mem [256];
    logic [31:0] ref_mem [256];
    int          slave_lat = 1;
    int          slave_cnt = 0;
    logic [31:0] slave_rd = 32'h0;
    int          overlap_err = 0;
    int          valid_run = 0;
    int          long_pulse = 0;
    int          both_ready = 0;
    bit          model_last_d = 1'b0;
    int          last_cyc_i;
    int          last_cyc_d;
    logic [31:0] last_dat_i;
    logic [31:0] last_dat_d;

    always #5 clock = ~clock;

    bram_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .bram_valid (bram_valid),
        .bram_instr (bram_instr),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata),
        .bram_ready (bram_ready)
    );

    // BRAM slave: answers each request slave_lat cycles later; rdata is noise outside the ready pulse.
    always @(posedge clock) begin
        #2;
        bram_ready = 1'b0;
        bram_rdata = $urandom();
        if (slave_cnt > 0) begin
            slave_cnt--;
            if (slave_cnt == 0) begin
                bram_ready = 1'b1;
                bram_rdata = slave_rd;
            end
        end
        if (bram_valid === 1'b1) begin
            if (slave_cnt != 0) overlap_err++;
            issue_q.push_back('{bram_addr, bram_wdata, bram_wstrb, bram_instr});
            slave_rd = slave_mem[bram_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (bram_wstrb[b]) slave_mem[bram_addr[9:2]][8*b +: 8] = bram_wdata[8*b +: 8];
            end
            slave_cnt = slave_lat;
            valid_run++;
            if (valid_run > 1) long_pulse++;
        end else begin
            valid_run = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic dv,
                                 input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
        imem_valid = iv;
        imem_addr  = ia;
        dmem_valid = dv;
        dmem_addr  = da;
        dmem_wdata = dw;
        dmem_wstrb = ds;
    endtask

    function automatic bit inRange(input logic [31:0] a);
        longint la;
        la = longint'({32'h0, a});
        return (la >= longint'({32'h0, BASE})) && (la < longint'({32'h0, TOP}));
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = TOP + 32'($urandom_range(0, 63) * 4);
            1: r = 32'hFFFF_FFFC - 32'($urandom_range(0, 15) * 4);
            default: r = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        endcase
        return r;
    endfunction

    // One transaction per enabled requester, both raised in the same cycle when both enabled.
    task automatic runPair(input logic i_en, input logic [31:0] i_addr,
                           input logic d_en, input logic [31:0] d_addr,
                           input logic [31:0] d_wdata, input logic [3:0] d_wstrb,
                           input string tag);
        bit          order [2];
        int          n_ord = 0;
        int          idle = 0;
        int          exp_cyc_i = 0;
        int          exp_cyc_d = 0;
        int          got_cyc_i = 0;
        int          got_cyc_d = 0;
        logic [31:0] exp_dat_i = 32'h0;
        logic [31:0] exp_dat_d = 32'h0;
        logic [31:0] got_dat_i = 32'h0;
        logic [31:0] got_dat_d = 32'h0;
        bit          chk_dat_d = 1'b0;
        bit          first_d;
        issue_t      exp_q[$];
        int          n = 0;

        if (i_en && d_en) begin
`ifdef ROUND_ROBIN_EN
            first_d = !model_last_d;
`else
            first_d = 1'b1;
`endif
            order[0] = first_d;
            order[1] = !first_d;
            n_ord = 2;
        end else if (i_en || d_en) begin
            order[0] = d_en;
            n_ord = 1;
        end

        for (int k = 0; k < n_ord; k++) begin
            bit          is_d;
            logic [31:0] a;
            bit          hit;
            int          done_at;
            logic [31:0] data;
            is_d    = order[k];
            a       = is_d ? d_addr : i_addr;
            hit     = inRange(a);
            done_at = idle + (hit ? 2 + slave_lat : 2);
            data    = hit ? ref_mem[a[9:2]] : 32'h0;
            if (hit) begin
                exp_q.push_back('{a, is_d ? d_wdata : 32'h0, is_d ? d_wstrb : 4'h0, !is_d});
                if (is_d) begin
                    for (int b = 0; b < 4; b++) begin
                        if (d_wstrb[b]) ref_mem[a[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
                    end
                end
            end
            if (is_d) begin
                exp_cyc_d = done_at;
                exp_dat_d = data;
                chk_dat_d = (d_wstrb == 4'h0) || !hit;
            end else begin
                exp_cyc_i = done_at;
                exp_dat_i = data;
            end
            idle = done_at + 1;
            model_last_d = is_d;
        end

        applyStimulus(i_en, i_addr, d_en, d_addr, d_wdata, d_wstrb);
        while (((i_en && got_cyc_i == 0) || (d_en && got_cyc_d == 0)) && n < 100) begin
            @(negedge clock);
            n++;
            if (imem_ready === 1'b1 && dmem_ready === 1'b1) both_ready++;
            if (imem_ready === 1'b1) begin
                if (got_cyc_i == 0) begin
                    got_cyc_i = n;
                    got_dat_i = imem_rdata;
                end
                imem_valid = 1'b0;
                imem_addr  = $urandom();
            end
            if (dmem_ready === 1'b1) begin
                if (got_cyc_d == 0) begin
                    got_cyc_d = n;
                    got_dat_d = dmem_rdata;
                end
                dmem_valid = 1'b0;
                dmem_addr  = $urandom();
                dmem_wdata = $urandom();
            end
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;

        checkOutput({tag, "_cyc_i"}, got_cyc_i, exp_cyc_i);
        checkOutput({tag, "_cyc_d"}, got_cyc_d, exp_cyc_d);
        if (i_en) checkOutput({tag, "_rdata_i"}, got_dat_i, exp_dat_i);
        if (d_en && chk_dat_d) checkOutput({tag, "_rdata_d"}, got_dat_d, exp_dat_d);
        checkOutput({tag, "_nissue"}, 32'(issue_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < issue_q.size(); k++) begin
            checkOutput({tag, "_baddr"},  issue_q[k].addr,         exp_q[k].addr);
            checkOutput({tag, "_bwdata"}, issue_q[k].wdata,        exp_q[k].wdata);
            checkOutput({tag, "_bwstrb"}, 32'(issue_q[k].wstrb),   32'(exp_q[k].wstrb));
            checkOutput({tag, "_binstr"}, 32'(issue_q[k].instr),   32'(exp_q[k].instr));
        end
        issue_q.delete();

        @(negedge clock);
        checkOutput({tag, "_ready_low"}, 32'({imem_ready, dmem_ready}), 32'h0);
        if (i_en) checkOutput({tag, "_hold_i"}, imem_rdata, got_dat_i);
        if (d_en) checkOutput({tag, "_hold_d"}, dmem_rdata, got_dat_d);

        last_cyc_i = got_cyc_i;
        last_cyc_d = got_cyc_d;
        last_dat_i = got_dat_i;
        last_dat_d = got_dat_d;
    endtask

    initial begin
        string got_order;
        string exp_order;
        int    il;
        int    dl;
        int    seen;
        bit    last;
        bit    g;

        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
            ref_mem[i]   = {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
        end
        slave_mem[32'h100 >> 2] = 32'hDEADBEEF;
        ref_mem[32'h100 >> 2]   = 32'hDEADBEEF;

        #1;
        checkOutput("reset_bram_valid", 32'(bram_valid), 32'h0);
        checkOutput("reset_imem_ready", 32'(imem_ready), 32'h0);
        checkOutput("reset_dmem_ready", 32'(dmem_ready), 32'h0);
        checkOutput("reset_bram_addr", bram_addr, 32'h0);
        checkOutput("reset_imem_rdata", imem_rdata, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single instruction fetch, one-cycle BRAM.
        slave_lat = 1;
        runPair(1'b1, 32'h100, 1'b0, 32'h0, 32'h1111_2222, 4'h0, "req023");
        checkOutput("req023_lat", last_cyc_i, 3);
        checkOutput("req023_data", last_dat_i, 32'hDEADBEEF);

        // Both requesters streaming four reads each from the same cycle.
        got_order = "";
        exp_order = "";
        last = model_last_d;
        il = 4;
        dl = 4;
        while (il > 0 || dl > 0) begin
`ifdef ROUND_ROBIN_EN
            g = (il > 0 && dl > 0) ? !last : (dl > 0);
`else
            g = (dl > 0);
`endif
            exp_order = {exp_order, g ? "D" : "I"};
            if (g) dl--; else il--;
            last = g;
        end
        model_last_d = last;
        il = 4;
        dl = 4;
        applyStimulus(1'b1, 32'h300, 1'b1, 32'h380, 32'h0, 4'h0);
        for (int n = 0; n < 300 && (il > 0 || dl > 0); n++) begin
            @(negedge clock);
            if (imem_ready === 1'b1 && dmem_ready === 1'b1) both_ready++;
            if (dmem_ready === 1'b1) begin
                got_order = {got_order, "D"};
                dl--;
                if (dl <= 0) dmem_valid = 1'b0;
                else dmem_addr = dmem_addr + 32'h4;
            end
            if (imem_ready === 1'b1) begin
                got_order = {got_order, "I"};
                il--;
                if (il <= 0) imem_valid = 1'b0;
                else imem_addr = imem_addr + 32'h4;
            end
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        total++;
        assert (got_order == exp_order) else begin
            bad++;
            $error("FAIL req025_order observed=%s expected=%s", got_order, exp_order);
        end
        checkOutput("req025_nissue", 32'(issue_q.size()), 32'd8);
        issue_q.delete();
        @(negedge clock);

        // Data write with a slow BRAM.
        slave_lat = 4;
        runPair(1'b0, 32'h0, 1'b1, 32'h200, 32'h12345678, 4'hF, "req024");
        checkOutput("req024_lat", last_cyc_d, 6);

        // Address range boundaries.
        slave_lat = 2;
        runPair(1'b0, 32'h0, 1'b1, 32'h100000, 32'hCAFE_F00D, 4'h0, "req026");
        checkOutput("req026_lat", last_cyc_d, 2);
        checkOutput("req026_data", last_dat_d, 32'h0);
        runPair(1'b1, 32'h000F_FFFC, 1'b0, 32'h0, 32'h0, 4'h0, "top_minus4");
        runPair(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 32'hA0B0_C0D0, 4'h5, "mixed_edge");

        // Reset while the BRAM access is outstanding; the late bram_ready must be dropped.
        slave_lat = 3;
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clock);
        checkOutput("rst_issue_pulse", 32'(bram_valid), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rst_bram_valid", 32'(bram_valid), 32'h0);
        checkOutput("rst_bram_addr", bram_addr, 32'h0);
        checkOutput("rst_bram_instr", 32'(bram_instr), 32'h0);
        checkOutput("rst_bram_wdata", bram_wdata, 32'h0);
        checkOutput("rst_bram_wstrb", 32'(bram_wstrb), 32'h0);
        checkOutput("rst_readies", 32'({imem_ready, dmem_ready}), 32'h0);
        checkOutput("rst_imem_rdata", imem_rdata, 32'h0);
        checkOutput("rst_dmem_rdata", dmem_rdata, 32'h0);
        imem_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (imem_ready !== 1'b0 || dmem_ready !== 1'b0 || bram_valid !== 1'b0) seen++;
        end
        checkOutput("rst_no_activity", seen, 0);
        checkOutput("rst_nissue", 32'(issue_q.size()), 32'd1);
        issue_q.delete();
        model_last_d = 1'b0;
        slave_lat = 1;
        runPair(1'b1, 32'h44, 1'b0, 32'h0, 32'h0, 4'h0, "post_rst");
        checkOutput("post_rst_lat", last_cyc_i, 3);

        // Random single and simultaneous requests.
        for (int it = 0; it < 40; it++) begin
            int          kind;
            logic [31:0] ia;
            logic [31:0] da;
            logic [31:0] dw;
            logic [3:0]  ds;
            kind = $urandom_range(0, 2);
            ia   = randAddr();
            da   = randAddr();
            dw   = $urandom();
            ds   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            slave_lat = $urandom_range(1, 4);
            runPair(kind != 1, ia, kind != 0, da, dw, ds, $sformatf("rnd%0d", it));
        end

        checkOutput("overlap", overlap_err, 0);
        checkOutput("long_pulse", long_pulse, 0);
        checkOutput("both_ready", both_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
